// File: rtl/stream_channel_arbiter.sv
// Round-robin packet arbiter: merges NUM_CH AXI-Stream inputs onto one output
// with a single registered output stage, keeping each packet contiguous.
module stream_channel_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 5
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic [NUM_CH-1:0]            s_tready,
  input  logic [NUM_CH-1:0]            ch_enable,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic [2:0]                   m_tdest,
  output logic [NUM_CH*16-1:0]         pkt_count
);

  localparam int IDX_W = 3;
  localparam int SLOTS = 1 << IDX_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q;
  logic                  m_tlast_q;
  logic [IDX_W-1:0]      m_tdest_q;
  logic [15:0]           pkt_count_q [NUM_CH];

  logic [SLOTS-1:0]      req_pad, valid_pad, last_pad;
  logic [DATA_WIDTH-1:0] s_data [SLOTS];
  logic                  arb_hit;
  logic [IDX_W-1:0]      arb_pick, arb_idx;
  logic                  out_free, accept, accept_last;

  // Per-channel vectors are padded to a power of two so they can be indexed
  // directly by the 3-bit grant without range concerns.
  assign req_pad   = SLOTS'(s_tvalid & ch_enable);
  assign valid_pad = SLOTS'(s_tvalid);
  assign last_pad  = SLOTS'(s_tlast);

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_CH) begin : g_used
      assign s_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign s_data[i] = '0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    assign pkt_count[i*16 +: 16] = pkt_count_q[i];
  end

  // Scan from farthest to nearest so the nearest requester after last_grant
  // is the one left in arb_pick.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = '0;
    arb_idx  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      arb_idx = IDX_W'((int'(last_grant_q) + k) % NUM_CH);
      if (req_pad[arb_idx]) begin
        arb_hit  = 1'b1;
        arb_pick = arb_idx;
      end
    end
  end

  assign out_free    = !m_tvalid_q || m_tready;
  assign accept      = (state_q == ST_BUSY) && out_free && valid_pad[grant_q] && !areset;
  assign accept_last = accept && last_pad[grant_q];

  always_comb begin
    s_tready = '0;
    if ((state_q == ST_BUSY) && out_free && !areset) begin
      s_tready = NUM_CH'(SLOTS'(1) << grant_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          state_d      = ST_BUSY;
          grant_d      = arb_pick;
          last_grant_d = arb_pick;
        end
      end
      ST_BUSY: begin
        if (accept_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdest_q    <= '0;
      // NOTE: the data register and counters are reset too; they are outputs with defined reset values.
      m_tdata_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pkt_count_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (accept) begin
        m_tdata_q  <= s_data[grant_q];
        m_tlast_q  <= last_pad[grant_q];
        m_tdest_q  <= grant_q;
        m_tvalid_q <= 1'b1;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
      if (accept_last) begin
        pkt_count_q[grant_q] <= pkt_count_q[grant_q] + 16'd1;
      end
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdest  = m_tdest_q;

endmodule

// File: tb/tb_stream_channel_arbiter.sv
// Directed bench for stream_channel_arbiter: per-channel packet sources, an
// output beat log compared against hand-built expected sequences.
module tb_stream_channel_arbiter;

  localparam int DW = 64;
  localparam int NC = 5;

  typedef struct packed {
    logic [2:0]    dest;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic             clk;
  logic             areset;
  logic [NC*DW-1:0] s_tdata;
  logic [NC-1:0]    s_tvalid, s_tlast, s_tready, ch_enable;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tready, m_tlast;
  logic [2:0]       m_tdest;
  logic [NC*16-1:0] pkt_count;

  stream_channel_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .aclk      (clk),
    .areset    (areset),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .ch_enable (ch_enable),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tdest   (m_tdest),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  int src_len [NC];
  int src_npk [NC];
  int src_beat[NC];
  int src_seq [NC];

  beat_t got_q[$];
  beat_t exp_q[$];
  bit    log_en     = 1'b1;
  bit    rdy_toggle = 1'b0;
  int    n_out      = 0;
  int    scen_cyc   = 0;
  int    first_mv   = -1;
  int    rdy2_cnt   = 0;
  int    stall_bad  = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int ch, input int seq);
    return {8'(ch), 56'(seq)};
  endfunction

  task automatic load(input int ch, input int len, input int npk);
    src_len[ch]  = len;
    src_npk[ch]  = npk;
    src_beat[ch] = 0;
    src_seq[ch]  = 0;
  endtask

  task automatic ep(input int ch, input int seq, input bit last);
    beat_t b;
    b.dest = 3'(ch);
    b.last = last;
    b.data = mk(ch, seq);
    exp_q.push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      s_tvalid[i]            = (src_npk[i] > 0);
      s_tlast[i]             = (src_beat[i] == src_len[i] - 1);
      s_tdata[i*DW +: DW]    = mk(i, src_seq[i]);
    end
    m_tready = rdy_toggle ? (scen_cyc % 2 == 0) : 1'b1;
  endtask

  task automatic step();
    logic [NC-1:0] acc;
    beat_t cur;
    drive();
    #1;
    cur.dest = m_tdest;
    cur.last = m_tlast;
    cur.data = m_tdata;
    if (m_tvalid && m_tready) begin
      n_out++;
      if (log_en) got_q.push_back(cur);
    end
    if (m_tvalid && first_mv < 0) first_mv = scen_cyc;
    if (s_tready[2]) rdy2_cnt++;
    if (prev_stall && (m_tvalid !== 1'b1 || cur !== prev_beat)) stall_bad++;
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = cur;
    acc = s_tvalid & s_tready;
    @(posedge clk);
    if (!areset) begin
      for (int i = 0; i < NC; i++) begin
        if (acc[i]) begin
          src_seq[i]++;
          src_beat[i]++;
          if (src_beat[i] == src_len[i]) begin
            src_beat[i] = 0;
            src_npk[i]--;
          end
        end
      end
    end
    scen_cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_dut();
    areset = 1'b1;
    for (int i = 0; i < NC; i++) load(i, 1, 0);
    ch_enable  = '1;
    rdy_toggle = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    areset     = 1'b0;
    scen_cyc   = 0;
    first_mv   = -1;
    rdy2_cnt   = 0;
    stall_bad  = 0;
    prev_stall = 1'b0;
    n_out      = 0;
    log_en     = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    areset    = 1'b1;
    m_tready  = 1'b1;
    ch_enable = '1;
    s_tdata   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    for (int i = 0; i < NC; i++) load(i, 1, 0);
    repeat (3) @(negedge clk);
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_mlast", m_tlast, 1'b0);
    check("rst_mdest", m_tdest, 3'd0);
    check("rst_mdata", m_tdata, 64'd0);
    check("rst_sready", s_tready, 5'd0);
    check("rst_pktcnt", pkt_count, 80'd0);

    // Channel 2 alone, one 4-beat packet, sink always ready.
    reset_dut();
    load(2, 4, 1);
    run(12);
    ep(2, 0, 0); ep(2, 1, 0); ep(2, 2, 0); ep(2, 3, 1);
    compare_q("single");
    check("single_lat", first_mv, 2);
    check("single_cnt2", pkt_count[2*16 +: 16], 16'd1);

    // All channels continuously offering 1-beat packets: strict rotation.
    reset_dut();
    for (int i = 0; i < NC; i++) load(i, 1, 2);
    run(26);
    for (int p = 0; p < 2; p++) for (int c = 0; c < NC; c++) ep(c, p, 1);
    compare_q("rr");
    check("rr_cnt0", pkt_count[0 +: 16], 16'd2);
    check("rr_cnt4", pkt_count[4*16 +: 16], 16'd2);

    // 8-beat packet on channel 1 with the sink toggling ready every cycle.
    reset_dut();
    rdy_toggle = 1'b1;
    load(1, 8, 1);
    run(40);
    for (int b = 0; b < 8; b++) ep(1, b, b == 7);
    compare_q("stall");
    check("stall_stable", stall_bad, 0);
    check("stall_cnt1", pkt_count[16 +: 16], 16'd1);

    // Channel 2 disabled while everyone requests.
    reset_dut();
    ch_enable = 5'b11011;
    for (int i = 0; i < NC; i++) load(i, 1, 1);
    run(20);
    ep(0, 0, 1); ep(1, 0, 1); ep(3, 0, 1); ep(4, 0, 1);
    compare_q("dis");
    check("dis_rdy2", rdy2_cnt, 0);
    check("dis_cnt2", pkt_count[2*16 +: 16], 16'd0);
    check("dis_cnt3", pkt_count[3*16 +: 16], 16'd1);

    // Enable dropped mid-packet: the granted packet still completes.
    reset_dut();
    load(1, 4, 1);
    run(2);
    ch_enable = 5'b11101;
    run(15);
    for (int b = 0; b < 4; b++) ep(1, b, b == 3);
    compare_q("midclr");
    check("midclr_cnt1", pkt_count[16 +: 16], 16'd1);

    // Reset pulse during the 3rd beat of a channel-4 packet.
    reset_dut();
    load(4, 6, 1);
    run(3);
    areset = 1'b1;
    step();
    areset = 1'b0;
    check("rstmid_mvalid", m_tvalid, 1'b0);
    check("rstmid_pktcnt", pkt_count, 80'd0);
    load(0, 1, 1);
    run(25);
    ep(4, 0, 0); ep(4, 1, 0);
    ep(0, 0, 1);
    ep(4, 2, 0); ep(4, 3, 0); ep(4, 4, 0); ep(4, 5, 1);
    compare_q("rstmid");
    check("rstmid_cnt0", pkt_count[0 +: 16], 16'd1);
    check("rstmid_cnt4", pkt_count[4*16 +: 16], 16'd1);

    // 65537 single-beat packets on channel 0: counter wraps to 1.
    reset_dut();
    log_en = 1'b0;
    load(0, 1, 65537);
    run(2 * 65537 + 6);
    check("wrap_beats", n_out, 65537);
    check("wrap_cnt0", pkt_count[0 +: 16], 16'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_channel_arbiter.md
STREAM_CHANNEL_ARBITER -- requirements
Module: stream_channel_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the tdata width in bits of every port (8..512, multiple of 8).
REQ-002 The block SHALL have parameter NUM_CH, default 5, meaning the number of input streams (2..8; channel index order AR=0, AW=1, R=2, W=3, B=4).
REQ-003 The block SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port areset, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port s_tdata, input, NUM_CH*DATA_WIDTH, the input data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 The block SHALL have port s_tvalid, input, NUM_CH, the per-channel valid.
REQ-007 The block SHALL have port s_tlast, input, NUM_CH, the per-channel end-of-packet marker.
REQ-008 The block SHALL have port s_tready, output, NUM_CH, the per-channel ready.
REQ-009 The block SHALL have port ch_enable, input, NUM_CH, the per-channel arbitration enable.
REQ-010 The block SHALL have port m_tdata, output, DATA_WIDTH, the merged output data.
REQ-011 The block SHALL have port m_tvalid, output, 1, the output valid.
REQ-012 The block SHALL have port m_tready, input, 1, the output ready.
REQ-013 The block SHALL have port m_tlast, output, 1, the output end-of-packet marker.
REQ-014 The block SHALL have port m_tdest, output, 3, the source channel index of the current beat.
REQ-015 The block SHALL have port pkt_count, output, NUM_CH*16, the per-channel count of completed packets; it wraps modulo 2^16.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held by channel g).
REQ-017 In IDLE, the block SHALL select a channel i where s_tvalid[i] and ch_enable[i] are both 1, searching round-robin from (last_grant+1) mod NUM_CH upward with wrap; on a hit it SHALL register g=i, set last_grant=i and enter BUSY on the next edge.
REQ-018 In IDLE, no s_tready bit SHALL be asserted.
REQ-019 In BUSY, s_tready[g] SHALL equal (!m_tvalid || m_tready) and all other s_tready bits SHALL be 0.
REQ-020 An input beat SHALL be accepted when s_tvalid[g] and s_tready[g] are both 1; on that edge it SHALL be loaded into the output register (m_tdata, m_tlast, m_tdest=g, m_tvalid=1), giving latency of exactly 1 cycle from acceptance to m_tvalid.
REQ-021 m_tvalid SHALL clear when m_tready=1 and no new beat is loaded that cycle; m_tdata, m_tlast and m_tdest SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-022 Simultaneous output drain and input load SHALL sustain 1 beat/cycle with no bubble inside a packet.
REQ-023 Acceptance of a beat with s_tlast[g]=1 SHALL increment pkt_count[g] by 1 (wrapping 0xFFFF to 0x0000) and return the FSM to IDLE on the same edge.
REQ-024 Minimum packet-to-packet gap on the input side SHALL be 1 cycle (the IDLE arbitration cycle).
REQ-025 ch_enable SHALL be sampled only in IDLE; deasserting ch_enable[g] while BUSY SHALL NOT abort the packet, and the grant SHALL hold until tlast.
REQ-026 A channel whose ch_enable bit is 0 SHALL never be granted and SHALL see s_tready=0.
REQ-027 While BUSY with s_tvalid[g]=0, the block SHALL wait indefinitely with no timeout and no regrant.
REQ-028 When all channels request simultaneously, grants SHALL rotate so that each enabled channel is served once per NUM_CH packets.

Reset
REQ-029 While areset=1, at each rising edge the block SHALL set the FSM to IDLE, set last_grant=NUM_CH-1 (so channel 0 wins first), set m_tvalid=0, m_tlast=0, m_tdest=0, m_tdata=0, s_tready=0 and every pkt_count field to 0.
REQ-030 Reset asserted mid-packet SHALL drop the partial packet and the buffered beat; the next grant after reset SHALL follow REQ-017 from channel 0.

Verification
REQ-031 The bench SHALL cover: channel 2 only, 4-beat packet, m_tready=1 -> m_tdest=2 on all 4 beats, m_tlast on beat 4 only, first m_tvalid 2 cycles after s_tvalid, pkt_count[2]=1.
REQ-032 The bench SHALL cover: all 5 channels hold 1-beat packets continuously for 10 packets -> m_tdest sequence 0,1,2,3,4,0,1,2,3,4.
REQ-033 The bench SHALL cover: m_tready toggling 1/0 every cycle during an 8-beat packet -> all 8 beats delivered in order with no data changes while stalled and no duplicates.
REQ-034 The bench SHALL cover: ch_enable=5'b11011 with all channels valid -> channel 2 is never granted and s_tready[2]=0 throughout; clearing ch_enable[1] mid-packet -> that packet still completes.
REQ-035 The bench SHALL cover: areset pulse on the 3rd beat of channel 4's packet -> m_tvalid=0 and pkt_count all zero the cycle after, then the next grant goes to channel 0 if it is valid.
REQ-036 The bench SHALL cover: 65537 1-beat packets on channel 0 -> pkt_count[0]=1 (wrap).
